// File: rtl/dsi_lane_ctrl_gen2_if.sv
// rtl/dsi_lane_ctrl_gen2_if.sv - packet-assembler handshake and PHY-side signal bundle of one D-PHY lane
interface dsi_lane_ctrl_gen2_if #(
    parameter int LANE_BYTES = 1
);
    logic                    lines_enable;
    logic [1:0]              mode;
    logic                    start_rqst;
    logic                    fin_rqst;
    logic [8*LANE_BYTES-1:0] inp_data;
    logic                    ulps_exit_rqst;
    logic                    data_rqst;
    logic                    active;
    logic                    ulps_active;
    logic [8*LANE_BYTES-1:0] hs_output;
    logic                    hs_enable;
    logic                    LP_p_output;
    logic                    LP_n_output;
    logic                    lp_lines_enable;

    modport master (
        output lines_enable, mode, start_rqst, fin_rqst, inp_data, ulps_exit_rqst,
        input  data_rqst, active, ulps_active, hs_output, hs_enable,
               LP_p_output, LP_n_output, lp_lines_enable
    );

    modport slave (
        input  lines_enable, mode, start_rqst, fin_rqst, inp_data, ulps_exit_rqst,
        output data_rqst, active, ulps_active, hs_output, hs_enable,
               LP_p_output, LP_n_output, lp_lines_enable
    );
endinterface

// File: rtl/dsi_lane_ctrl_gen2.sv
// rtl/dsi_lane_ctrl_gen2.sv - D-PHY lane controller: HS burst, LPDT and (DSI_LANE_ULPS_EN) ULPS sequencing
module dsi_lane_ctrl_gen2 #(
    parameter int MODE       = 0,
    parameter int LANE_BYTES = 1,
    parameter int T_LPX      = 3,
    parameter int T_HS_PREP  = 3,
    parameter int T_HS_ZERO  = 6,
    parameter int T_HS_TRAIL = 4,
    parameter int T_HS_EXIT  = 3,
    parameter int LP_BAUD    = 30,
    parameter int T_WAKEUP   = 1000
) (
    input  logic                clk_sys,
    input  logic                rst,
    dsi_lane_ctrl_gen2_if.slave lane
);
    localparam int W = 8 * LANE_BYTES;

    function automatic logic [15:0] reload(input int t);
        return (t < 1) ? 16'd0 : 16'(t - 1);
    endfunction

    localparam logic [15:0]  C_LPX    = reload(T_LPX);
    localparam logic [15:0]  C_PREP   = reload(T_HS_PREP);
    localparam logic [15:0]  C_ZERO   = reload(T_HS_ZERO);
    localparam logic [15:0]  C_TRAIL  = reload(T_HS_TRAIL);
    localparam logic [15:0]  C_EXIT   = reload(T_HS_EXIT);
    localparam logic [15:0]  C_BAUD   = reload(LP_BAUD);
    localparam logic [15:0]  C_WAKE   = reload(T_WAKEUP);
    localparam logic [15:0]  C_HALF   = 16'(LP_BAUD / 2);
    localparam logic [W-1:0] SYNC_WORD = W'(8'hB8) << (W - 8);
    localparam logic [W-1:0] CLK_WORD  = {LANE_BYTES{8'hAA}};

    typedef enum logic [3:0] {
        DISABLED, IDLE, HS_RQST, HS_PREP, HS_ZERO, HS_SYNC, HS_ACTIVE, HS_TRAIL, HS_EXIT,
        ESC_ENTRY, ESC_CMD, LPDT_DATA, MARK_ONE
`ifdef DSI_LANE_ULPS_EN
        , ULPS_HOLD, ULPS_WAKE
`endif
    } state_t;

    state_t         state, state_next;
    logic [15:0]    cnt, load;
    logic [1:0]     step;
    logic [2:0]     bit_idx;
    logic [7:0]     esc_byte, cmd_byte;
    logic           last_byte, trail_bit, esc_lpdt;
    logic           done, byte_end, hs_drive, cur_bit, first_half;
    logic           lp_p, lp_n;
    logic [W-1:0]   hs_q;
    logic           hs_en_q, lp_en_q, lp_p_q, lp_n_q;

`ifdef DSI_LANE_ULPS_EN
    logic esc_ulps;
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
            esc_ulps <= 1'b0;
        else if (state == IDLE && state_next == ESC_ENTRY)
            esc_ulps <= (lane.mode == 2'b10);
    end
    assign esc_lpdt         = !esc_ulps;
    assign lane.ulps_active = (state == ULPS_HOLD);
    assign lane.active      = !(state == DISABLED || state == IDLE || state == ULPS_HOLD);
`else
    assign esc_lpdt         = 1'b1;
    assign lane.ulps_active = 1'b0;
    assign lane.active      = !(state == DISABLED || state == IDLE);
`endif

    assign cmd_byte   = esc_lpdt ? 8'hE1 : 8'h1E;
    assign done       = (cnt == 16'd0);
    assign byte_end   = done && (bit_idx == 3'd7);
    assign hs_drive   = (state == HS_ZERO) || (state == HS_SYNC) ||
                        (state == HS_ACTIVE) || (state == HS_TRAIL);
    // Command bits go out MSB first, LPDT payload LSB first.
    assign cur_bit    = (state == ESC_CMD) ? esc_byte[3'd7 - bit_idx] : esc_byte[bit_idx];
    assign first_half = (cnt >= C_HALF);

    assign lane.data_rqst = (state == HS_ACTIVE) ||
                            (state == ESC_CMD && byte_end && esc_lpdt) ||
                            (state == LPDT_DATA && byte_end && !last_byte);

    always_comb begin
        state_next = state;
        case (state)
            DISABLED:  if (lane.lines_enable) state_next = IDLE;
            IDLE: begin
                if (!lane.lines_enable)
                    state_next = DISABLED;
                else if (lane.start_rqst) begin
                    if (lane.mode == 2'b00)
                        state_next = HS_RQST;
                    else if (MODE == 0 && lane.mode == 2'b01)
                        state_next = ESC_ENTRY;
`ifdef DSI_LANE_ULPS_EN
                    else if (MODE == 0 && lane.mode == 2'b10)
                        state_next = ESC_ENTRY;
`endif
                end
            end
            HS_RQST:   if (done) state_next = HS_PREP;
            HS_PREP:   if (done) state_next = HS_ZERO;
            HS_ZERO:   if (done) state_next = (MODE == 1) ? HS_ACTIVE : HS_SYNC;
            HS_SYNC:   state_next = HS_ACTIVE;
            HS_ACTIVE: if (lane.fin_rqst) state_next = HS_TRAIL;
            HS_TRAIL:  if (done) state_next = HS_EXIT;
            HS_EXIT:   if (done) state_next = IDLE;
            ESC_ENTRY: if (done && step == 2'd3) state_next = ESC_CMD;
            ESC_CMD: begin
                if (byte_end) begin
`ifdef DSI_LANE_ULPS_EN
                    state_next = esc_lpdt ? LPDT_DATA : ULPS_HOLD;
`else
                    state_next = LPDT_DATA;
`endif
                end
            end
            LPDT_DATA: if (byte_end && last_byte) state_next = MARK_ONE;
            MARK_ONE:  if (done) state_next = IDLE;
`ifdef DSI_LANE_ULPS_EN
            ULPS_HOLD: if (lane.ulps_exit_rqst) state_next = ULPS_WAKE;
            ULPS_WAKE: if (done) state_next = IDLE;
`endif
            default:   state_next = DISABLED;
        endcase
    end

    always_comb begin
        load = 16'd0;
        case (state_next)
            HS_RQST, ESC_ENTRY, MARK_ONE: load = C_LPX;
            HS_PREP:                      load = C_PREP;
            HS_ZERO:                      load = C_ZERO;
            HS_TRAIL:                     load = C_TRAIL;
            HS_EXIT:                      load = C_EXIT;
            ESC_CMD, LPDT_DATA:           load = C_BAUD;
`ifdef DSI_LANE_ULPS_EN
            ULPS_WAKE:                    load = C_WAKE;
`endif
            default:                      load = 16'd0;
        endcase
    end

    always_comb begin
        lp_p = 1'b0;
        lp_n = 1'b0;
        case (state)
            DISABLED, IDLE, HS_EXIT: begin lp_p = 1'b1; lp_n = 1'b1; end
            HS_RQST:                 lp_n = 1'b1;
            ESC_ENTRY: begin
                lp_p = (step == 2'd0);
                lp_n = (step == 2'd2);
            end
            ESC_CMD, LPDT_DATA: begin
                lp_p = cur_bit && first_half;
                lp_n = !cur_bit && first_half;
            end
            MARK_ONE:                lp_p = 1'b1;
`ifdef DSI_LANE_ULPS_EN
            ULPS_WAKE:               lp_p = 1'b1;
`endif
            default:                 ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state     <= DISABLED;
            cnt       <= 16'd0;
            step      <= 2'd0;
            bit_idx   <= 3'd0;
            esc_byte  <= 8'd0;
            last_byte <= 1'b0;
            trail_bit <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt     <= load;
                step    <= 2'd0;
                bit_idx <= 3'd0;
            end else if (done) begin
                cnt     <= load;
                step    <= step + 2'd1;
                bit_idx <= bit_idx + 3'd1;
            end else begin
                cnt <= cnt - 16'd1;
            end
            if (state == ESC_ENTRY && state_next == ESC_CMD)
                esc_byte <= cmd_byte;
            else if (lane.data_rqst && state != HS_ACTIVE) begin
                esc_byte  <= lane.inp_data[7:0];
                last_byte <= lane.fin_rqst;
            end
            if (state == HS_ACTIVE)
                trail_bit <= (MODE == 1) ? !CLK_WORD[W-1] : !lane.inp_data[W-1];
        end
    end

    // PHY-facing outputs are registered together so HS and LP drivers never overlap.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            hs_q    <= '0;
            hs_en_q <= 1'b0;
            lp_en_q <= 1'b0;
            lp_p_q  <= 1'b1;
            lp_n_q  <= 1'b1;
        end else begin
            hs_en_q <= hs_drive;
            lp_en_q <= !(hs_drive || state == DISABLED);
            lp_p_q  <= lp_p;
            lp_n_q  <= lp_n;
            case (state)
                HS_SYNC:   hs_q <= SYNC_WORD;
                HS_ACTIVE: hs_q <= (MODE == 1) ? CLK_WORD : lane.inp_data;
                HS_TRAIL:  hs_q <= {W{trail_bit}};
                default:   hs_q <= '0;
            endcase
        end
    end

    assign lane.hs_output       = hs_q;
    assign lane.hs_enable       = hs_en_q;
    assign lane.lp_lines_enable = lp_en_q;
    assign lane.LP_p_output     = lp_p_q;
    assign lane.LP_n_output     = lp_n_q;
endmodule

// File: tb/tb_dsi_lane_ctrl_gen2.sv
// tb/tb_dsi_lane_ctrl_gen2.sv - scoreboard bench for dsi_lane_ctrl_gen2 (data lane x2 bytes, clock lane x1 byte)
module tb_dsi_lane_ctrl_gen2;
    localparam int TLPX = 3, TPREP = 3, TZERO = 6, TTRAIL = 4, TEXIT = 3, BAUD = 30, TWAKE = 1000;

    typedef logic [21:0] tup_t;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    dsi_lane_ctrl_gen2_if #(.LANE_BYTES(2)) ifc0();
    dsi_lane_ctrl_gen2_if #(.LANE_BYTES(1)) ifc1();

    dsi_lane_ctrl_gen2 #(.MODE(0), .LANE_BYTES(2)) dut0 (.clk_sys(clk_sys), .rst(rst), .lane(ifc0.slave));
    dsi_lane_ctrl_gen2 #(.MODE(1), .LANE_BYTES(1)) dut1 (.clk_sys(clk_sys), .rst(rst), .lane(ifc1.slave));

    int   n_chk = 0, n_fail = 0, rq_cnt = 0;
    bit   mon_en = 0, sel = 0;
    logic act_d0 = 0, ulps_d0 = 0, act_d1 = 0;
    tup_t exp_t[$];
    int   exp_n[$];
    logic [15:0] wq[$];
    logic [7:0]  bq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output tuple: {ulps, active, hs_en, lp_en, Dp, Dn, hs_word}; undriven fields masked.
    function automatic tup_t mk(input bit u, input bit a, input bit he, input bit le,
                                input bit p, input bit n, input logic [15:0] w);
        return {u, a, he, le, le ? p : 1'b0, le ? n : 1'b0, he ? w : 16'h0};
    endfunction

    function automatic void push(input tup_t t, input int n);
        if (exp_t.size() != 0 && exp_t[$] == t && exp_n[$] != 0 && n != 0)
            exp_n[$] = exp_n[$] + n;
        else begin
            exp_t.push_back(t);
            exp_n.push_back(n);
        end
    endfunction

    function automatic tup_t sample();
        if (!sel)
            return mk(ulps_d0, act_d0, ifc0.hs_enable, ifc0.lp_lines_enable,
                      ifc0.LP_p_output, ifc0.LP_n_output, ifc0.hs_output);
        return mk(1'b0, act_d1, ifc1.hs_enable, ifc1.lp_lines_enable,
                  ifc1.LP_p_output, ifc1.LP_n_output, {8'h00, ifc1.hs_output});
    endfunction

    always @(posedge clk_sys) begin
        act_d0  <= ifc0.active;
        ulps_d0 <= ifc0.ulps_active;
        act_d1  <= ifc1.active;
    end

    task automatic finish_run(input tup_t t, input int n);
        tup_t et;
        int   en;
        if (!t[21] && !t[20]) return;
        if (exp_t.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_unexpected: got %0h for %0d cycles expected no activity", t, n);
            return;
        end
        et = exp_t.pop_front();
        en = exp_n.pop_front();
        check("run_value", 32'(t), 32'(et));
        if (en != 0) check("run_length", n, en);
    endtask

    // Monitor: run-length encodes the lane outputs and scores each finished run.
    initial begin
        tup_t cur, smp;
        int   len;
        cur = '0;
        len = 0;
        forever begin
            @(negedge clk_sys);
            smp = sample();
            if (!sel && ifc0.data_rqst) rq_cnt++;
            if (!mon_en) begin
                cur = smp;
                len = 0;
            end else if (smp == cur) len++;
            else begin
                finish_run(cur, len);
                cur = smp;
                len = 1;
            end
        end
    end

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_t.size() != 0 && i < 3000) begin
            @(negedge clk_sys);
            i++;
        end
        check(name, exp_t.size(), 0);
        exp_t.delete();
        exp_n.delete();
    endtask

    task automatic start0(input logic [1:0] m);
        ifc0.mode = m;
        ifc0.start_rqst = 1'b1;
        @(negedge clk_sys);
        ifc0.start_rqst = 1'b0;
    endtask

    task automatic wait_rqst0(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (ifc0.data_rqst) begin ok = 1; return; end
            @(negedge clk_sys);
        end
    endtask

    task automatic push_entry();
        push(mk(0, 1, 0, 1, 1, 0, 0), TLPX);
        push(mk(0, 1, 0, 1, 0, 0, 0), TLPX);
        push(mk(0, 1, 0, 1, 0, 1, 0), TLPX);
        push(mk(0, 1, 0, 1, 0, 0, 0), TLPX);
    endtask

    task automatic push_esc(input logic [7:0] v, input bit msb_first);
        for (int i = 0; i < 8; i++) begin
            bit b;
            b = msb_first ? v[7 - i] : v[i];
            push(mk(0, 1, 0, 1, b, !b, 0), BAUD / 2);
            push(mk(0, 1, 0, 1, 0, 0, 0), BAUD / 2);
        end
    endtask

    task automatic hs_burst0();
        bit ok;
        push(mk(0, 1, 0, 1, 0, 1, 0), TLPX);
        push(mk(0, 1, 0, 1, 0, 0, 0), TPREP);
        push(mk(0, 1, 1, 0, 0, 0, 16'h0000), TZERO);
        push(mk(0, 1, 1, 0, 0, 0, 16'hB800), 1);
        foreach (wq[i]) push(mk(0, 1, 1, 0, 0, 0, wq[i]), 1);
        push(mk(0, 1, 1, 0, 0, 0, wq[$][15] ? 16'h0000 : 16'hFFFF), TTRAIL);
        push(mk(0, 1, 0, 1, 1, 1, 0), TEXIT);
        start0(2'b00);
        wait_rqst0(ok);
        check("hs_rqst_seen", ok, 1);
        foreach (wq[i]) begin
            ifc0.inp_data = wq[i];
            ifc0.fin_rqst = (i == wq.size() - 1);
            @(posedge clk_sys);
            @(negedge clk_sys);
        end
        ifc0.fin_rqst = 1'b0;
        drain("hs_drain");
    endtask

    task automatic lpdt0();
        bit ok;
        push_entry();
        push_esc(8'hE1, 1);
        foreach (bq[i]) push_esc(bq[i], 0);
        push(mk(0, 1, 0, 1, 1, 0, 0), TLPX);
        rq_cnt = 0;
        start0(2'b01);
        foreach (bq[i]) begin
            wait_rqst0(ok);
            check("lpdt_rqst_seen", ok, 1);
            ifc0.inp_data = {8'($urandom), bq[i]};
            ifc0.fin_rqst = (i == bq.size() - 1);
            @(posedge clk_sys);
            @(negedge clk_sys);
            ifc0.fin_rqst = 1'b0;
        end
        drain("lpdt_drain");
        check("lpdt_rqst_pulses", rq_cnt, bq.size());
    endtask

    task automatic idle_stays0(input string name, input logic [1:0] m);
        bit seen;
        seen = 0;
        start0(m);
        repeat (20) begin
            seen |= ifc0.active;
            @(negedge clk_sys);
        end
        check(name, seen, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        ifc0.lines_enable = 0; ifc0.mode = 0; ifc0.start_rqst = 0; ifc0.fin_rqst = 0;
        ifc0.inp_data = 0; ifc0.ulps_exit_rqst = 0;
        ifc1.lines_enable = 0; ifc1.mode = 0; ifc1.start_rqst = 0; ifc1.fin_rqst = 0;
        ifc1.inp_data = 0; ifc1.ulps_exit_rqst = 0;
        repeat (3) @(negedge clk_sys);
        check("rst_lp_p", ifc0.LP_p_output, 1);
        check("rst_lp_n", ifc0.LP_n_output, 1);
        check("rst_lp_en", ifc0.lp_lines_enable, 0);
        check("rst_hs", {ifc0.hs_enable, ifc0.hs_output}, 0);
        check("rst_flags", {ifc0.data_rqst, ifc0.active, ifc0.ulps_active}, 0);
        rst = 0;
        repeat (2) @(negedge clk_sys);
        check("disabled_lp_en", ifc0.lp_lines_enable, 0);
        ifc0.lines_enable = 1;
        ifc1.lines_enable = 1;
        repeat (3) @(negedge clk_sys);
        check("idle_lp", {ifc0.lp_lines_enable, ifc0.LP_p_output, ifc0.LP_n_output}, 3'b111);
        check("idle_rest", {ifc0.hs_enable, ifc0.hs_output, ifc0.data_rqst, ifc0.active}, 0);
        mon_en = 1;

        wq = {16'h1234, 16'h8001};
        hs_burst0();
        bq = {8'hA5, 8'h3C};
        lpdt0();
        repeat (3) begin
            wq.delete();
            repeat ($urandom_range(1, 4)) wq.push_back(16'($urandom));
            hs_burst0();
        end
        repeat (2) begin
            bq.delete();
            repeat ($urandom_range(1, 3)) bq.push_back(8'($urandom));
            lpdt0();
        end
        idle_stays0("mode11_ignored", 2'b11);

`ifdef DSI_LANE_ULPS_EN
        push_entry();
        push_esc(8'h1E, 1);
        push(mk(1, 0, 0, 1, 0, 0, 0), 0);
        push(mk(0, 1, 0, 1, 1, 0, 0), TWAKE);
        start0(2'b10);
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk_sys);
            ok = ifc0.ulps_active;
        end
        check("ulps_hold_seen", ok, 1);
        repeat (20) @(negedge clk_sys);
        ifc0.ulps_exit_rqst = 1;
        @(negedge clk_sys);
        ifc0.ulps_exit_rqst = 0;
        drain("ulps_drain");
`else
        idle_stays0("mode10_ignored", 2'b10);
`endif

        // Clock lane: escape requests ignored, HS burst carries fixed AA without sync.
        mon_en = 0;
        sel = 1;
        @(negedge clk_sys);
        mon_en = 1;
        begin
            bit seen;
            seen = 0;
            ifc1.mode = 2'b01;
            ifc1.start_rqst = 1;
            @(negedge clk_sys);
            ifc1.start_rqst = 0;
            repeat (20) begin seen |= ifc1.active; @(negedge clk_sys); end
            check("clk_lane_lpdt_ignored", seen, 0);
        end
        push(mk(0, 1, 0, 1, 0, 1, 0), TLPX);
        push(mk(0, 1, 0, 1, 0, 0, 0), TPREP);
        push(mk(0, 1, 1, 0, 0, 0, 16'h0000), TZERO);
        push(mk(0, 1, 1, 0, 0, 0, 16'h00AA), 3);
        push(mk(0, 1, 1, 0, 0, 0, 16'h0000), TTRAIL);
        push(mk(0, 1, 0, 1, 1, 1, 0), TEXIT);
        ifc1.mode = 2'b00;
        ifc1.start_rqst = 1;
        @(negedge clk_sys);
        ifc1.start_rqst = 0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = ifc1.data_rqst;
            if (!ok) @(negedge clk_sys);
        end
        check("clk_lane_rqst_seen", ok, 1);
        for (int i = 0; i < 3; i++) begin
            ifc1.inp_data = 8'($urandom);
            ifc1.fin_rqst = (i == 2);
            @(posedge clk_sys);
            @(negedge clk_sys);
        end
        ifc1.fin_rqst = 0;
        drain("clk_lane_drain");
        mon_en = 0;
        sel = 0;

        // Asynchronous reset in the middle of HS_ACTIVE.
        start0(2'b00);
        wait_rqst0(ok);
        check("rst_test_rqst_seen", ok, 1);
        ifc0.inp_data = 16'h5A5A;
        @(posedge clk_sys);
        #2;
        check("pre_rst_hs_en", ifc0.hs_enable, 1);
        rst = 1;
        #1;
        check("mid_rst_hs", {ifc0.hs_enable, ifc0.hs_output}, 0);
        check("mid_rst_lp", {ifc0.lp_lines_enable, ifc0.LP_p_output, ifc0.LP_n_output}, 3'b011);
        check("mid_rst_flags", {ifc0.data_rqst, ifc0.active}, 0);
        @(negedge clk_sys);
        rst = 0;
        repeat (4) @(negedge clk_sys);
        check("post_rst_idle", {ifc0.lp_lines_enable, ifc0.active}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
